uart_tx_fifo: RTL and testbench

Next-generation UART transmitter with an internal bit-rate divider and an input FIFO.

---
 rtl/uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, runtime frame format and an internal bit-rate divider.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_W      = 16,
  localparam int CNT_W      = $clog2(DATA_W + 1),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [CNT_W-1:0]  char_len,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              tx,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK  = 3'd5,
    S_MAB    = 3'd6
`endif
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              r_tx;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_baud;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shreg;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_two_stop;
  logic              r_stop2;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_last_stop;
  logic              w_brk_req;
  logic [CNT_W-1:0]  w_len;
  logic [DATA_W-1:0] w_rd_data;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_W = CNT_W + 1;
  logic [BRK_W-1:0] r_brk_cnt;
  logic             w_brk_min;
  assign w_brk_req = send_break;
  assign w_brk_min = r_brk_cnt >= (BRK_W'(r_len) + BRK_W'(2));
`else
  assign w_brk_req = 1'b0;
`endif

  // Write handshake: wr_en is the valid, !full the ready; a write is taken on an
  // edge where both hold, otherwise it is dropped and overflow pulses next cycle.
  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push      = wr_en && !w_full;
  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_bit_end   = (r_div == r_baud);
  assign w_last_stop = !r_two_stop || r_stop2;
  assign w_len       = (char_len < CNT_W'(5) || char_len > CNT_W'(DATA_W)) ?
                       CNT_W'(DATA_W) : char_len;

  function automatic logic [DATA_W-1:0] len_mask(input logic [CNT_W-1:0] len);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (CNT_W'(i) < len);
    return m;
  endfunction

  // A character leaves the FIFO only on the way into START, never during BREAK.
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty && !w_brk_req) begin
      if (r_state == S_IDLE) w_pop = 1'b1;
      else if (r_state == S_STOP && w_bit_end && w_last_stop) w_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // tx is registered from the current state, so the line lags the state by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_div      <= '0;
      r_baud     <= '0;
      r_len      <= CNT_W'(DATA_W);
      r_idx      <= '0;
      r_shreg    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_brk_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_START:  r_tx <= 1'b0;
        S_DATA:   r_tx <= r_shreg[0];
        S_PARITY: r_tx <= r_par_bit;
`ifdef UART_TX_BREAK_EN
        S_BREAK:  r_tx <= 1'b0;
`endif
        default:  r_tx <= 1'b1;
      endcase

      r_div <= w_bit_end ? '0 : r_div + DIV_W'(1);

      if (w_pop) begin
        r_state    <= S_START;
        r_div      <= '0;
        r_baud     <= baud_div;
        r_len      <= w_len;
        r_par_en   <= parity_en;
        r_two_stop <= two_stop;
        r_stop2    <= 1'b0;
        r_shreg    <= w_rd_data;
        r_par_bit  <= (^(w_rd_data & len_mask(w_len))) ^ parity_odd;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_div <= '0;
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
              r_state   <= S_BREAK;
              r_baud    <= baud_div;
              r_len     <= w_len;
              r_brk_cnt <= '0;
            end
`endif
          end
          S_START: begin
            if (w_bit_end) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_shreg <= r_shreg >> 1;
              r_idx   <= r_idx + CNT_W'(1);
              if (r_idx == r_len - CNT_W'(1)) begin
                r_state <= r_par_en ? S_PARITY : S_STOP;
                r_stop2 <= 1'b0;
              end
            end
          end
          S_PARITY: begin
            if (w_bit_end) r_state <= S_STOP;
          end
          S_STOP: begin
            if (w_bit_end) begin
              if (!w_last_stop) begin
                r_stop2 <= 1'b1;
`ifdef UART_TX_BREAK_EN
              end else if (send_break) begin
                r_state   <= S_BREAK;
                r_baud    <= baud_div;
                r_len     <= w_len;
                r_brk_cnt <= '0;
`endif
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
`ifdef UART_TX_BREAK_EN
          S_BREAK: begin
            if (w_bit_end) begin
              if (!w_brk_min) r_brk_cnt <= r_brk_cnt + BRK_W'(1);
              else if (!send_break) r_state <= S_MAB;
            end
          end
          S_MAB: begin
            if (w_bit_end) r_state <= S_IDLE;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign tx        = r_tx;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a serial monitor decodes every frame on tx and
// compares it, cycle by cycle, against frames the bench predicts when it writes.
module tb_uart_tx_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DIV_W-1:0]  baud_div = '0;
  logic [CNT_W-1:0]  char_len = '0;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              two_stop = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full, empty, overflow, tx, busy;
  logic [LVL_W-1:0]  level;
  logic [2:0]        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  // Each entry: [31:20] clocks per bit, [19:16] bit count, [15:0] line bits in send order.
  logic [31:0] exp_q[$];
  logic        mon_active = 1'b0;
  int          frame_no = 0;
  logic [7:0]  ov_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .char_len(char_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty), .level(level),
    .overflow(overflow), .tx(tx), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_frame(input logic [7:0] d, input int len,
                                             input bit pen, input bit podd,
                                             input bit two, input int baud);
    logic [15:0] b;
    int n;
    bit p;
    if (len < 5 || len > DATA_W) len = DATA_W;
    b = '0;
    n = 1;
    p = podd;
    for (int i = 0; i < len; i++) begin
      b[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (pen) begin
      b[n] = p;
      n++;
    end
    b[n] = 1'b1;
    n++;
    if (two) begin
      b[n] = 1'b1;
      n++;
    end
    return {12'(baud + 1), 4'(n), b};
  endfunction

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(make_frame(d, int'(char_len), parity_en, parity_odd, two_stop, int'(baud_div)));
  endtask

  task automatic write_char(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    push_exp(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !mon_active) break;
    end
    check(tag, 32'(i < max_cycles), 32'd1);
  endtask

  // Serial monitor: every clock of every bit must match the predicted line level.
  initial begin : monitor
    logic [31:0] e;
    logic [15:0] got;
    logic        stable;
    logic        aborted;
    int          nb;
    int          per;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(exp_q.size()), 32'd1);
          for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx === 1'b1) break;
          end
        end else begin
          e = exp_q.pop_front();
          nb = int'(e[19:16]);
          per = int'(e[31:20]);
          got = '0;
          stable = 1'b1;
          aborted = 1'b0;
          mon_active = 1'b1;
          for (int k = 0; k < nb && !aborted; k++) begin
            for (int c = 0; c < per && !aborted; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (rst !== 1'b1) aborted = 1'b1;
              else if (c == 0) got[4'(k)] = tx;
              else if (tx !== got[4'(k)]) stable = 1'b0;
            end
          end
          if (!aborted) begin
            check($sformatf("frame%0d_bits", frame_no), 32'(got), 32'(e[15:0]));
            check($sformatf("frame%0d_timing", frame_no), 32'(stable), 32'd1);
          end
          frame_no++;
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int bc;
    baud_div = 16'd3;
    char_len = 4'd8;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, 4 clocks per bit, 8N1: latency and busy length
    wr_en = 1'b1;
    wr_data = 8'hA5;
    push_exp(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat_empty_n", 32'(empty), 32'd0);
    check("lat_level_n", 32'(level), 32'd1);
    check("lat_busy_n", 32'(busy), 32'd0);
    check("lat_tx_n", 32'(tx), 32'd1);
    @(negedge clk);
    check("lat_busy_n1", 32'(busy), 32'd1);
    check("lat_empty_n1", 32'(empty), 32'd1);
    check("lat_tx_n1", 32'(tx), 32'd1);
    @(negedge clk);
    check("lat_tx_n2", 32'(tx), 32'd0);
    bc = 2;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) bc++;
      else break;
    end
    check("a5_busy_cycles", 32'(bc), 32'd40);
    wait_done("a5_drain", 200);

    // parity: even and odd on 0xA5, then 7-bit 0xFF even
    parity_en = 1'b1;
    parity_odd = 1'b0;
    write_char(8'hA5);
    wait_done("par_even_drain", 200);
    parity_odd = 1'b1;
    write_char(8'hA5);
    wait_done("par_odd_drain", 200);
    parity_odd = 1'b0;
    char_len = 4'd7;
    write_char(8'hFF);
    wait_done("par_len7_drain", 200);
    parity_en = 1'b0;
    char_len = 4'd8;

    // back-to-back, two stop bits, one clock per bit
    two_stop = 1'b1;
    baud_div = 16'd0;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h00;
    push_exp(8'h00);
    @(negedge clk);
    wr_data = 8'hFF;
    push_exp(8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bc++;
      else break;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 32'(bc), 32'd22);
    wait_done("b2b_drain", 100);
    two_stop = 1'b0;

    // overflow with a 4-deep FIFO
    baud_div = 16'd15;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level_full", 32'(level), 32'd4);
        check("ovf_pulse_before", 32'(overflow), 32'd0);
      end
      wr_en = 1'b1;
      wr_data = ov_data[i];
      if (i < 5) push_exp(ov_data[i]);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level_kept", 32'(level), 32'd4);
    @(negedge clk);
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    wait_done("ovf_drain", 1200);

    // char_len changed mid-frame only affects the next frame
    baud_div = 16'd3;
    write_char(8'h3C);
    repeat (8) @(negedge clk);
    char_len = 4'd5;
    write_char(8'hF3);
    wait_done("len_drain", 300);
    char_len = 4'd8;

    // asynchronous reset in the middle of the data bits
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h55;
    push_exp(8'h55);
    @(negedge clk);
    wr_data = 8'h0F;
    push_exp(8'h0F);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_level", 32'(level), 32'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    write_char(8'hC3);
    wait_done("post_rst_drain", 200);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
